uart_tx_scheduler: RTL and testbench

Shares one UART transmitter between NUM_REQ byte producers using round-robin arbitration with packet locking. A requester holds the transmitter until it sends a byte flagged last. The block sequences the transmitter with a one-cycle start pulse and waits for its done pulse. A watchdog aborts a byte if done never arrives. It sits between producers (command responders, debug streams) and the UART TX datapath, mirroring the RX side.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 51 +++++
 rtl/uart_tx_scheduler.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit scheduler.
//   tx_state_e      : scheduler FSM encoding (IDLE -> START -> WAIT_DONE)
//   DEFAULT_DATA_W  : default byte width
//   GID_W           : width of a requester index (supports up to 8 requesters)
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int GID_W          = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter with a lock override.
//   i_req      : request vector, one bit per requester
//   i_ptr      : last served requester; search starts at i_ptr+1 (mod N)
//   i_lock_en  : when set, only i_lock_id may win
//   i_lock_id  : requester holding the lock
//   o_grant    : one-hot grant (all zero when nobody eligible requests)
//   o_idx      : index of the granted requester (0 when no grant)
//   o_any      : a grant was issued
// ---------------------------------------------------------------------------
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GID_W-1:0]   i_ptr,
  input  logic               i_lock_en,
  input  logic [GID_W-1:0]   i_lock_id,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [GID_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    if (i_lock_en) begin
      // A locked packet blocks everyone else, even while its owner is idle.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_lock_id == GID_W'(i) && i_req[i]) begin
          o_grant[i] = 1'b1;
          o_idx      = GID_W'(i);
          o_any      = 1'b1;
        end
      end
    end else begin
      // Offsets 1..NUM_REQ visit every requester once, the previous winner last.
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!o_any && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
          o_grant[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
          o_idx = GID_W'((int'(i_ptr) + k) % NUM_REQ);
          o_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter between NUM_REQ byte producers. Round-robin
// arbitration between packets; the winner keeps the transmitter until it
// sends a byte flagged last. Each byte is launched with a one-cycle tx_start
// and the block then waits for tx_done, aborting through a watchdog.
//
// Handshake: a byte moves from requester i when req_valid[i] && req_ready[i]
// at a rising clock edge. req_ready is combinational, only ever asserted in
// IDLE, and at most one bit is high; producers hold valid/data/last stable
// until accepted.
//
// Ports:
//   clock, reset           : clock, synchronous active-low reset
//   req_valid/last/data    : per-requester byte offer (data packed DATA_W each)
//   req_ready              : per-requester accept
//   tx_data, tx_start      : byte and one-cycle start pulse to the transmitter
//   tx_done                : one-cycle completion pulse from the transmitter
//   grant_id, grant_valid  : current owner, byte in flight
//   locked                 : packet lock held
//   timeout_err            : one-cycle pulse on watchdog abort
//   dbg_state              : FSM state (tx_state_e encoding)
// ---------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 65535
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_done,
  output logic [GID_W-1:0]          grant_id,
  output logic                      grant_valid,
  output logic                      locked,
  output logic                      timeout_err,
  output logic [1:0]                dbg_state
);

  // The START cycle already counts against the budget and the abort pulse is
  // registered, so expiry is taken when the WAIT_DONE count shows TIMEOUT-2.
  // That places timeout_err exactly TIMEOUT cycles after tx_start.
  localparam logic [15:0] LP_WD_EXPIRE = 16'(TIMEOUT - 2);
  localparam logic [15:0] LP_WD_MAX    = 16'(TIMEOUT);

  tx_state_e          r_state;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_tx_start;
  logic [GID_W-1:0]   r_grant_id;
  logic               r_locked;
  logic [GID_W-1:0]   r_lock_id;
  logic               r_timeout_err;
  logic [GID_W-1:0]   r_rr_ptr;
  logic [15:0]        r_wd;

  logic [NUM_REQ-1:0] w_grant;
  logic [GID_W-1:0]   w_idx;
  logic               w_any;
  logic [DATA_W-1:0]  w_data;
  logic               w_last;
  logic               w_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .i_lock_en (r_locked),
    .i_lock_id (r_lock_id),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_data = '0;
    w_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_data = req_data[i*DATA_W +: DATA_W];
        w_last = req_last[i];
      end
    end
  end

  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign w_fire    = (r_state == IDLE) && w_any;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_grant_id    <= '0;
      r_locked      <= 1'b0;
      r_lock_id     <= '0;
      r_timeout_err <= 1'b0;
      r_rr_ptr      <= GID_W'(NUM_REQ - 1);
      r_wd          <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_tx_data  <= w_data;
            r_grant_id <= w_idx;
            r_tx_start <= 1'b1;
            r_state    <= START;
            if (w_last) begin
              r_locked <= 1'b0;
              r_rr_ptr <= w_idx;
            end else begin
              r_locked  <= 1'b1;
              r_lock_id <= w_idx;
            end
          end
        end
        START: begin
          r_tx_start <= 1'b0;
          r_wd       <= '0;
          r_state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Done has priority over a coincident expiry.
          if (tx_done) begin
            r_state <= IDLE;
          end else if (r_wd == LP_WD_EXPIRE) begin
            r_timeout_err <= 1'b1;
            r_locked      <= 1'b0;
            r_rr_ptr      <= r_grant_id;
            r_wd          <= r_wd + 16'd1;
            r_state       <= IDLE;
          end else if (r_wd != LP_WD_MAX) begin
            r_wd <= r_wd + 16'd1;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign grant_id    = r_grant_id;
  assign grant_valid = (r_state != IDLE);
  assign locked      = r_locked;
  assign timeout_err = r_timeout_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Self-checking bench: producer sources held in per-requester arrays, a
// transmitter model with programmable done latency (or silence), and a
// packet-level reference model that predicts the byte order into exp_q.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int NR        = 4;
  localparam int DW        = 8;
  localparam int TO        = 20;
  localparam int SRC_DEPTH = 32;
  localparam int W         = 12;  // {id[2:0], last, data[7:0]}

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_last  = '0;
  logic [NR*DW-1:0] req_data  = '0;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    tx_data;
  logic             tx_start;
  logic             tx_done = 1'b0;
  logic [2:0]       grant_id;
  logic             grant_valid;
  logic             locked;
  logic             timeout_err;
  logic [1:0]       dbg_state;

  uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_done(tx_done), .grant_id(grant_id), .grant_valid(grant_valid),
    .locked(locked), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // producer sources
  logic [7:0] src_data [NR][SRC_DEPTH];
  bit         src_last [NR][SRC_DEPTH];
  int         src_cnt  [NR];
  int         src_head [NR];
  int         mdl_head [NR];

  // scoreboard and model state
  logic [W-1:0] exp_q[$];
  logic [7:0]   started_log[$];
  int  m_rr = NR - 1;
  bit  m_locked = 0;
  int  m_lock_id = 0;

  // monitor / transmitter model state
  bit         prev_acc_any = 0;
  int         acc_idx = 0;
  int         t_since = -1;
  int         win_len = 0;
  int         done_cd = -1;
  int         txm_lat = 10;
  bit         silent = 0;
  bit         stray_done = 0;
  bit         done_in_start = 0;
  logic [7:0] last_started = '0;
  int         terr_count = 0;

  int errors = 0;
  int checks = 0;

  // ---------------- source helpers ----------------
  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin
      src_cnt[i] = 0; src_head[i] = 0; mdl_head[i] = 0;
    end
    started_log.delete();
  endtask

  task automatic push_src(input int r, input logic [7:0] d, input bit l);
    src_data[r][src_cnt[r]] = d;
    src_last[r][src_cnt[r]] = l;
    src_cnt[r]++;
  endtask

  task automatic drive_requests();
    for (int i = 0; i < NR; i++) begin
      if (src_head[i] < src_cnt[i]) begin
        req_valid[i] = 1'b1;
        req_last[i]  = src_last[i][src_head[i]];
        req_data[i*DW +: DW] = src_data[i][src_head[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // Packet-level prediction: whole packets rotate among requesters that have
  // data, starting after the last one served; a lock owner without data
  // stalls everyone. When the transmitter is silent every byte is aborted,
  // which releases the lock and makes that requester the last served.
  task automatic model_run();
    int r;
    bit found;
    forever begin
      found = 0;
      r = 0;
      if (m_locked) begin
        r = m_lock_id;
        found = (mdl_head[r] < src_cnt[r]);
      end else begin
        for (int k = 1; k <= NR; k++) begin
          if (!found && mdl_head[(m_rr + k) % NR] < src_cnt[(m_rr + k) % NR]) begin
            r = (m_rr + k) % NR;
            found = 1;
          end
        end
      end
      if (!found) break;
      exp_q.push_back({3'(r), src_last[r][mdl_head[r]], src_data[r][mdl_head[r]]});
      if (silent || src_last[r][mdl_head[r]]) begin
        m_locked = 0;
        m_rr = r;
      end else begin
        m_locked = 1;
        m_lock_id = r;
      end
      mdl_head[r]++;
    end
  endtask

  // ---------------- one clock cycle: drive, then sample ----------------
  task automatic step();
    logic [W-1:0]  e;
    logic [NR-1:0] acc;
    bit exp_gv;
    bit exp_terr;
    @(negedge clock);
    if (prev_acc_any) src_head[acc_idx]++;
    drive_requests();
    if (t_since >= 0) t_since++;
    if (done_cd > 0) done_cd--;
    tx_done = 1'b0;
    if (done_cd == 0) begin tx_done = 1'b1; done_cd = -1; end
    if (stray_done) tx_done = 1'b1;
    if (done_in_start && prev_acc_any) tx_done = 1'b1;
    #1;
    checks++;
    if (tx_start !== prev_acc_any) begin
      errors++;
      $display("FAIL tx_start_timing: got %b want %b at %0t", tx_start, prev_acc_any, $time);
    end
    if (tx_start === 1'b1) begin
      t_since = 0;
      win_len = silent ? TO - 1 : txm_lat;
      if (!silent) done_cd = txm_lat;
      started_log.push_back(tx_data);
      last_started = tx_data;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: byte %0h from id %0d", tx_data, grant_id);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e[7:0] || grant_id !== e[11:9] || locked !== !e[8]) begin
          errors++;
          $display("FAIL byte_order: got data=%0h id=%0d locked=%b want data=%0h id=%0d locked=%b",
                   tx_data, grant_id, locked, e[7:0], e[11:9], !e[8]);
        end
      end
    end
    exp_gv = (t_since >= 0 && t_since <= win_len);
    checks++;
    if (grant_valid !== exp_gv) begin
      errors++;
      $display("FAIL grant_valid: got %b want %b (cycle %0d after start)", grant_valid, exp_gv, t_since);
    end
    exp_terr = silent && (t_since == TO);
    if (timeout_err === 1'b1) terr_count++;
    checks++;
    if (timeout_err !== exp_terr) begin
      errors++;
      $display("FAIL timeout_err: got %b want %b (cycle %0d after start)", timeout_err, exp_terr, t_since);
    end
    if (exp_terr) begin
      checks++;
      if (locked !== 1'b0) begin
        errors++;
        $display("FAIL lock_after_abort: got %b want 0", locked);
      end
    end
    if (exp_gv && tx_start !== 1'b1) begin
      checks++;
      if (tx_data !== last_started) begin
        errors++;
        $display("FAIL tx_data_stable: got %0h want %0h", tx_data, last_started);
      end
    end
    checks++;
    if ((req_ready & ~req_valid) != '0 || $countones(req_ready) > 1 || (exp_gv && req_ready != '0)) begin
      errors++;
      $display("FAIL req_ready: got %b with valid %b busy %b", req_ready, req_valid, exp_gv);
    end
    acc = req_valid & req_ready;
    if (reset !== 1'b1) acc = '0;
    prev_acc_any = |acc;
    for (int i = 0; i < NR; i++) if (acc[i]) acc_idx = i;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !prev_acc_any && (t_since < 0 || t_since > win_len + 1))
           && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_budget: %0d bytes still expected after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (src_head[i] !== mdl_head[i]) begin
        errors++;
        $display("FAIL consumed_bytes: requester %0d got %0d want %0d", i, src_head[i], mdl_head[i]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clock);
    if (prev_acc_any) src_head[acc_idx]++;
    prev_acc_any = 0;
    reset = 1'b0;
    req_valid = '0;
    tx_done = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || grant_id !== 3'd0 || locked !== 1'b0 ||
        timeout_err !== 1'b0 || grant_valid !== 1'b0 || dbg_state !== IDLE || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_state: start=%b data=%0h id=%0d locked=%b terr=%b gv=%b st=%0d ready=%b want all zero/IDLE",
               tx_start, tx_data, grant_id, locked, timeout_err, grant_valid, dbg_state, req_ready);
    end
    reset = 1'b1;
    t_since = -1;
    done_cd = -1;
    exp_q.delete();
    m_rr = NR - 1;
    m_locked = 0;
    m_lock_id = 0;
    for (int i = 0; i < NR; i++) mdl_head[i] = src_head[i];
  endtask

  task automatic test_rotation();
    logic [7:0] want [5];
    want[0] = 8'h10; want[1] = 8'h11; want[2] = 8'h12; want[3] = 8'h13; want[4] = 8'h10;
    test_reset();
    clear_sources();
    silent = 0;
    txm_lat = 10;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NR; i++) push_src(i, 8'(8'h10 + i), 1'b1);
    model_run();
    drain(400);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (started_log.size() <= k || started_log[k] !== want[k]) begin
        errors++;
        $display("FAIL rotation_seq[%0d]: got %0h want %0h", k,
                 (started_log.size() > k) ? started_log[k] : 8'hxx, want[k]);
      end
    end
    checks++;
    if (started_log.size() != 2 * NR) begin
      errors++;
      $display("FAIL start_count: got %0d want %0d", started_log.size(), 2 * NR);
    end
  endtask

  task automatic test_packet_lock();
    logic [7:0] want [7];
    want[0] = 8'h50; want[1] = 8'h60; want[2] = 8'hA0; want[3] = 8'hA1;
    want[4] = 8'hA2; want[5] = 8'h70; want[6] = 8'h51;
    test_reset();
    clear_sources();
    txm_lat = $urandom_range(2, 12);
    push_src(0, 8'h50, 1'b1); push_src(0, 8'h51, 1'b1);
    push_src(1, 8'h60, 1'b1);
    push_src(2, 8'hA0, 1'b0); push_src(2, 8'hA1, 1'b0); push_src(2, 8'hA2, 1'b1);
    push_src(3, 8'h70, 1'b1);
    model_run();
    drain(400);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (started_log.size() <= k || started_log[k] !== want[k]) begin
        errors++;
        $display("FAIL packet_seq[%0d]: got %0h want %0h", k,
                 (started_log.size() > k) ? started_log[k] : 8'hxx, want[k]);
      end
    end
  endtask

  task automatic test_lock_stall();
    test_reset();
    clear_sources();
    txm_lat = 6;
    push_src(1, 8'hB0, 1'b0);
    model_run();
    drain(200);
    push_src(0, 8'hC0, 1'b1);
    model_run();
    for (int c = 0; c < 50; c++) begin
      step();
      checks++;
      if (req_ready !== '0 || tx_start !== 1'b0 || locked !== 1'b1) begin
        errors++;
        $display("FAIL lock_stall: ready=%b start=%b locked=%b want 0/0/1 at cycle %0d",
                 req_ready, tx_start, locked, c);
      end
    end
    push_src(1, 8'hB1, 1'b1);
    model_run();
    drain(200);
  endtask

  task automatic test_timeout();
    test_reset();
    clear_sources();
    silent = 1;
    terr_count = 0;
    push_src(0, 8'hD0, 1'b0); push_src(0, 8'hD1, 1'b1);
    push_src(1, 8'hE0, 1'b1);
    model_run();
    drain(500);
    checks++;
    if (terr_count != 3) begin
      errors++;
      $display("FAIL timeout_count: got %0d want 3", terr_count);
    end
    silent = 0;
  endtask

  task automatic test_reset_mid_packet();
    int n;
    test_reset();
    clear_sources();
    silent = 1;
    push_src(2, 8'hF0, 1'b0); push_src(2, 8'hF1, 1'b1);
    exp_q.push_back({3'd2, 1'b0, 8'hF0});
    n = 0;
    while (t_since < 0 && n < 20) begin step(); n++; end
    repeat (5) step();
    checks++;
    if (locked !== 1'b1 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_lock: locked=%b gv=%b want 1/1", locked, grant_valid);
    end
    push_src(0, 8'h99, 1'b1);
    terr_count = 0;
    test_reset();
    silent = 0;
    txm_lat = 5;
    model_run();
    drain(300);
    checks++;
    if (terr_count != 0 || started_log.size() < 3 || started_log[1] !== 8'h99) begin
      errors++;
      $display("FAIL reset_priority: terr=%0d first_after_reset=%0h want 0 and 99",
               terr_count, (started_log.size() > 1) ? started_log[1] : 8'hxx);
    end
  endtask

  task automatic test_stray_done();
    test_reset();
    clear_sources();
    terr_count = 0;
    stray_done = 1;
    step();
    stray_done = 0;
    step();
    checks++;
    if (dbg_state !== IDLE || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle_done: state=%0d gv=%b want IDLE/0", dbg_state, grant_valid);
    end
    txm_lat = 8;
    done_in_start = 1;
    push_src(3, 8'h33, 1'b1);
    model_run();
    drain(200);
    done_in_start = 0;
    txm_lat = TO - 1;
    push_src(1, 8'h44, 1'b1);
    model_run();
    drain(200);
    checks++;
    if (terr_count != 0) begin
      errors++;
      $display("FAIL done_timeout_tie: got %0d error pulses want 0", terr_count);
    end
  endtask

  task automatic test_random();
    int npk, len;
    test_reset();
    clear_sources();
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < NR; i++) begin
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) push_src(i, 8'($urandom_range(0, 255)), (b == len - 1));
        end
      end
      txm_lat = $urandom_range(1, 15);
      model_run();
      drain(2000);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_rotation();
    test_packet_lock();
    test_lock_stall();
    test_timeout();
    test_reset_mid_packet();
    test_stray_done();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
